// File: rtl/complete_bipartite_valve_sequencer_pkg.sv
// Shared types for the 4x4 complete bipartite valve sequencer: phase enum,
// queued request record and the fabric edge index helper.
package complete_bipartite_valve_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_FLOW   = 2'd2,
    ST_FLUSH  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [1:0] src;
    logic [1:0] dst;
    logic [7:0] dur;
  } valve_req_t;

  localparam int REQ_W = $bits(valve_req_t);

  // Edge input_src -> output_dst maps to valve bit src*4+dst.
  function automatic logic [3:0] edge_idx(input logic [1:0] src, input logic [1:0] dst);
    return {src, dst};
  endfunction

endpackage

// File: rtl/complete_bipartite_valve_sequencer_valve_req_fifo.sv
// Synchronous FIFO holding pending valve requests; pointers wrap modulo DEPTH.
// Push is ignored when full and pop is ignored when empty.
module valve_req_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/complete_bipartite_valve_sequencer.sv
// Queues edge-open requests for a 4x4 complete bipartite valve fabric and runs
// each one as SETTLE -> FLOW -> FLUSH with a single registered valve bit open.
module complete_bipartite_valve_sequencer
  import complete_bipartite_valve_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int FLUSH_CYCLES  = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [1:0]                  req_src,
  input  logic [1:0]                  req_dst,
  input  logic [7:0]                  req_dur,
  output logic [15:0]                 valve_en,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(FIFO_DEPTH):0] pending
);

  seq_state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  valve_req_t cur, cur_nxt;
  valve_req_t req_in;
  valve_req_t fifo_head;
  logic [15:0] valve_nxt;
  logic       ready_en;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;

  assign req_in    = '{src: req_src, dst: req_dst, dur: req_dur};
  // ready_en holds req_ready low for the cycle right after a reset edge
  assign req_ready = ready_en && !fifo_full;

  valve_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid && req_ready),
    .wdata (req_in),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cur      <= '0;
      valve_en <= '0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur      <= cur_nxt;
      valve_en <= valve_nxt;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != 8'd0) ? cnt - 8'd1 : cnt;
    cur_nxt   = cur;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          cur_nxt   = fifo_head;
          state_nxt = ST_SETTLE;
          cnt_nxt   = 8'(SETTLE_CYCLES - 1);
        end
      end
      ST_SETTLE: begin
        if (cnt == 8'd0) begin
          if (cur.dur != 8'd0) begin
            state_nxt = ST_FLOW;
            cnt_nxt   = cur.dur - 8'd1;
          end else begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = 8'(FLUSH_CYCLES - 1);
          end
        end
      end
      ST_FLOW: begin
        if (cnt == 8'd0) begin
          state_nxt = ST_FLUSH;
          cnt_nxt   = 8'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (cnt == 8'd0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Valve drive follows the next phase so the open bit is registered
    valve_nxt = '0;
    if (state_nxt == ST_SETTLE || state_nxt == ST_FLOW)
      valve_nxt = 16'd1 << edge_idx(cur_nxt.src, cur_nxt.dst);
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FLUSH) && (cnt == 8'd0);

endmodule

// File: tb/tb_complete_bipartite_valve_sequencer.sv
// Directed and randomised bench for the valve sequencer; a negedge monitor
// checks every transfer's valve pattern, length and done pulse.
module tb_complete_bipartite_valve_sequencer;
  import complete_bipartite_valve_sequencer_pkg::*;

  localparam int SETTLE = 4;
  localparam int FLUSH  = 2;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_src;
  logic [1:0]  req_dst;
  logic [7:0]  req_dur;
  logic [15:0] valve_en;
  logic        busy;
  logic        done;
  logic [2:0]  pending;

  int n_checks = 0;
  int n_errors = 0;

  valve_req_t exp_q[$];
  valve_req_t mon_cur;
  bit         mon_en   = 1'b0;
  bit         in_xfer  = 1'b0;
  int         xfer_cyc = 0;
  int         done_cnt = 0;

  always #5 clk = ~clk;

  complete_bipartite_valve_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .FLUSH_CYCLES  (FLUSH),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .req_dur   (req_dur),
    .valve_en  (valve_en),
    .busy      (busy),
    .done      (done),
    .pending   (pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [1:0] d, input logic [7:0] du);
    bit ok = 1'b0;
    req_valid = 1'b1;
    req_src   = s;
    req_dst   = d;
    req_dur   = du;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        exp_q.push_back('{src: s, dst: d, dur: du});
      end
      step();
    end
    req_valid = 1'b0;
    check("send_accept", 32'(ok), 1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (!busy && pending == 3'd0 && exp_q.size() == 0) ok = 1'b1;
    end
    step();
    check("drain", 32'(ok), 1);
  endtask

  // Independent transfer model: valve bit for SETTLE+dur busy cycles, then
  // FLUSH closed cycles with done on the last one, then busy drops.
  always @(negedge clk) begin
    if (!mon_en) begin
      in_xfer = 1'b0;
    end else begin
      check("onehot", 32'($countones(valve_en) <= 1), 1);
      if (done) done_cnt++;
      if (busy) begin
        if (!in_xfer) begin
          in_xfer  = 1'b1;
          xfer_cyc = 0;
          check("xfer_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) mon_cur = exp_q.pop_front();
          else mon_cur = '0;
        end
        xfer_cyc++;
        check("xfer_valve", 32'(valve_en),
              (xfer_cyc <= SETTLE + int'(mon_cur.dur)) ?
              32'(16'd1 << edge_idx(mon_cur.src, mon_cur.dst)) : 32'd0);
        check("xfer_done", 32'(done), 32'(xfer_cyc == SETTLE + int'(mon_cur.dur) + FLUSH));
      end else begin
        if (in_xfer) begin
          check("xfer_len", xfer_cyc, SETTLE + int'(mon_cur.dur) + FLUSH);
          in_xfer = 1'b0;
        end
        check("idle_valve", 32'(valve_en), 0);
        check("idle_done", 32'(done), 0);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    int d0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_src   = '0;
    req_dst   = '0;
    req_dur   = '0;
    step();
    step();
    check("rst_valve",   32'(valve_en), 0);
    check("rst_busy",    32'(busy), 0);
    check("rst_done",    32'(done), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_ready",   32'(req_ready), 0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 32'(req_ready), 1);
    mon_en = 1'b1;

    // single request src=1 dst=2 dur=3
    send(2'd1, 2'd2, 8'd3);
    check("t1_valve", 32'(valve_en), 0);
    check("t1_pending", 32'(pending), 1);
    for (int i = 0; i < 7; i++) begin
      step();
      check("s1_valve", 32'(valve_en), 32'h0040);
      check("s1_done", 32'(done), 0);
    end
    step();
    check("s1_flush0_valve", 32'(valve_en), 0);
    check("s1_flush0_done", 32'(done), 0);
    step();
    check("s1_flush1_done", 32'(done), 1);
    check("s1_flush1_busy", 32'(busy), 1);
    step();
    check("s1_end_busy", 32'(busy), 0);

    // dur=0 skips FLOW
    send(2'd3, 2'd0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("s2_valve", 32'(valve_en), 32'h1000);
    end
    step();
    check("s2_flush0_valve", 32'(valve_en), 0);
    check("s2_flush0_done", 32'(done), 0);
    step();
    check("s2_flush1_done", 32'(done), 1);
    step();
    check("s2_end_busy", 32'(busy), 0);

    // fill the queue behind a long transfer
    send(2'd0, 2'd0, 8'd40);
    step();
    check("s3_blocker_busy", 32'(busy), 1);
    check("s3_blocker_pending", 32'(pending), 0);
    send(2'd0, 2'd1, 8'd1);
    send(2'd1, 2'd3, 8'd0);
    send(2'd2, 2'd2, 8'd2);
    send(2'd3, 2'd1, 8'd5);
    check("s3_full_pending", 32'(pending), 4);
    check("s3_full_ready", 32'(req_ready), 0);
    send(2'd3, 2'd3, 8'd1);
    check("s3_after5_pending", 32'(pending), 4);
    wait_idle(600);

    // reset during FLOW with two queued
    send(2'd2, 2'd1, 8'd20);
    send(2'd0, 2'd3, 8'd5);
    send(2'd1, 2'd1, 8'd5);
    for (int i = 0; i < 6; i++) step();
    check("s4_flow_valve", 32'(valve_en), 32'h0200);
    check("s4_flow_pending", 32'(pending), 2);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    step();
    check("s4_rst_valve", 32'(valve_en), 0);
    check("s4_rst_pending", 32'(pending), 0);
    check("s4_rst_done", 32'(done), 0);
    check("s4_rst_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    step();
    check("s4_ready", 32'(req_ready), 1);
    for (int i = 0; i < 30; i++) begin
      step();
      check("s4_quiet_busy", 32'(busy), 0);
      check("s4_quiet_valve", 32'(valve_en), 0);
      check("s4_quiet_done", 32'(done), 0);
    end
    exp_q.delete();
    mon_en = 1'b1;

    // randomised traffic
    d0 = done_cnt;
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) step();
      send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 6)));
    end
    wait_idle(5000);
    check("rand_done_count", done_cnt - d0, 200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
